// File: rtl/cheri_pkg.sv
// Shared types and constants for the stack-zeroization LSU arbiter slice.
//   arb_state_t : which requester currently drives the request phase of the data bus
//   owner_e     : owner of a granted bus beat, used to route responses
//   STKZ_WDATA  : write data for zeroization beats (also clears the capability tag)
//   STKZ_BE     : byte enables for zeroization beats (full word)
package cheri_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CORE,
        ARB_STKZ
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_STKZ = 1'b1
    } owner_e;

    localparam logic [32:0] STKZ_WDATA = '0;
    localparam logic [3:0]  STKZ_BE    = 4'hF;

endpackage

// File: rtl/cheri_owner_fifo.sv
// In-order FIFO of bus-beat owners, one entry per granted-but-unresponded transaction.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset (clears all entries)
//   push_i           store push_owner_i at the tail
//   push_owner_i     owner of the beat accepted this cycle
//   pop_i            drop the head entry (caller only pops when not empty)
//   head_owner_o     owner of the oldest outstanding beat
//   count_o          number of outstanding entries
//   empty_o, full_o  occupancy flags
module cheri_owner_fifo
    import cheri_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1),
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  owner_e          push_owner_i,
    input  logic            pop_i,
    output owner_e          head_owner_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    owner_e          mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '{default: OWN_CORE};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_owner_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop_i) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_owner_o = mem_q[rptr_q];
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CntW'(Depth));

endmodule

// File: rtl/cheri_stkz_lsu_arb.sv
// LSU-side arbiter between core load/stores and stack-zeroization word stores on one
// OBI-style data bus. Core traffic wins; a presented beat is held unchanged until granted.
// Granted beats are tracked by owner so in-order responses reach the right requester.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   core_*_i / core_gnt_o         core request phase (held until grant)
//   core_rvalid_o/rdata_o/err_o   core response phase
//   stkz_lsu_req_i/addr_i         zeroization store request
//   lsu_stkz_req_done_o           zeroization beat accepted on the bus
//   lsu_stkz_resp_valid_o/err_o   zeroization response
//   data_*_o / data_gnt_i         bus request phase
//   data_rvalid_i/rdata_i/err_i   bus response phase
//   unexp_rvalid_o                response arrived with nothing outstanding (dropped)
module cheri_stkz_lsu_arb
    import cheri_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [32:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [32:0] core_rdata_o,
    output logic        core_err_o,
    input  logic        stkz_lsu_req_i,
    input  logic [31:0] stkz_lsu_addr_i,
    output logic        lsu_stkz_req_done_o,
    output logic        lsu_stkz_resp_valid_o,
    output logic        lsu_stkz_resp_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [32:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [32:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        unexp_rvalid_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_t      state_q, state_d;
    logic            bus_req;
    owner_e          bus_owner;
    logic [29:0]     stkz_word_q;
    logic [29:0]     stkz_word;
    logic            stkz_word_en;
    logic            can_issue;

    logic            fifo_push, fifo_pop;
    owner_e          head_owner;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty, fifo_full;

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{core_addr_i[1:0], stkz_lsu_addr_i[1:0]};

    assign can_issue = ~fifo_full;

    // The engine is allowed to drop its request while its beat waits for grant, so
    // the stalled zeroization address is captured rather than read from the engine.
    assign stkz_word = (state_q == ARB_STKZ) ? stkz_word_q : stkz_lsu_addr_i[31:2];

    always_comb begin
        state_d      = state_q;
        bus_req      = 1'b0;
        bus_owner    = OWN_CORE;
        stkz_word_en = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (can_issue && core_req_i) begin
                    bus_req   = 1'b1;
                    bus_owner = OWN_CORE;
                    if (!data_gnt_i) state_d = ARB_CORE;
                end else if (can_issue && stkz_lsu_req_i) begin
                    bus_req   = 1'b1;
                    bus_owner = OWN_STKZ;
                    if (!data_gnt_i) begin
                        state_d      = ARB_STKZ;
                        stkz_word_en = 1'b1;
                    end
                end
            end
            ARB_CORE: begin
                bus_req   = 1'b1;
                bus_owner = OWN_CORE;
                if (data_gnt_i) state_d = ARB_IDLE;
            end
            ARB_STKZ: begin
                bus_req   = 1'b1;
                bus_owner = OWN_STKZ;
                if (data_gnt_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            stkz_word_q <= '0;
        end else begin
            state_q <= state_d;
            if (stkz_word_en) stkz_word_q <= stkz_lsu_addr_i[31:2];
        end
    end

    always_comb begin
        data_req_o   = bus_req;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (bus_req) begin
            if (bus_owner == OWN_CORE) begin
                data_we_o    = core_we_i;
                data_be_o    = core_be_i;
                data_addr_o  = {core_addr_i[31:2], 2'b00};
                data_wdata_o = core_wdata_i;
            end else begin
                data_we_o    = 1'b1;
                data_be_o    = STKZ_BE;
                data_addr_o  = {stkz_word, 2'b00};
                data_wdata_o = STKZ_WDATA;
            end
        end
    end

    assign fifo_push           = bus_req & data_gnt_i;
    assign fifo_pop            = data_rvalid_i & ~fifo_empty;
    assign core_gnt_o          = fifo_push & (bus_owner == OWN_CORE);
    assign lsu_stkz_req_done_o = fifo_push & (bus_owner == OWN_STKZ);

    cheri_owner_fifo #(
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (fifo_push),
        .push_owner_i (bus_owner),
        .pop_i        (fifo_pop),
        .head_owner_o (head_owner),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    assign core_rvalid_o         = fifo_pop & (head_owner == OWN_CORE);
    assign core_rdata_o          = core_rvalid_o ? data_rdata_i : '0;
    assign core_err_o            = core_rvalid_o & data_err_i;
    assign lsu_stkz_resp_valid_o = fifo_pop & (head_owner == OWN_STKZ);
    assign lsu_stkz_resp_err_o   = lsu_stkz_resp_valid_o & data_err_i;
    assign unexp_rvalid_o        = data_rvalid_i & fifo_empty;

    // Issue is suppressed at capacity, so occupancy can never exceed the limit.
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_count <= CntW'(MaxOutstanding));

endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
module tb_cheri_stkz_lsu_arb;

    localparam int unsigned MAX = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [3:0]  core_be_i = '0;
    logic [31:0] core_addr_i = '0;
    logic [32:0] core_wdata_i = '0;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic [32:0] core_rdata_o;
    logic        core_err_o;
    logic        stkz_lsu_req_i = 1'b0;
    logic [31:0] stkz_lsu_addr_i = '0;
    logic        lsu_stkz_req_done_o;
    logic        lsu_stkz_resp_valid_o;
    logic        lsu_stkz_resp_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [32:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [32:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;
    logic        unexp_rvalid_o;

    always #5 clk_i = ~clk_i;

    cheri_stkz_lsu_arb #(
        .MaxOutstanding (MAX)
    ) u_dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .core_req_i            (core_req_i),
        .core_we_i             (core_we_i),
        .core_be_i             (core_be_i),
        .core_addr_i           (core_addr_i),
        .core_wdata_i          (core_wdata_i),
        .core_gnt_o            (core_gnt_o),
        .core_rvalid_o         (core_rvalid_o),
        .core_rdata_o          (core_rdata_o),
        .core_err_o            (core_err_o),
        .stkz_lsu_req_i        (stkz_lsu_req_i),
        .stkz_lsu_addr_i       (stkz_lsu_addr_i),
        .lsu_stkz_req_done_o   (lsu_stkz_req_done_o),
        .lsu_stkz_resp_valid_o (lsu_stkz_resp_valid_o),
        .lsu_stkz_resp_err_o   (lsu_stkz_resp_err_o),
        .data_req_o            (data_req_o),
        .data_we_o             (data_we_o),
        .data_be_o             (data_be_o),
        .data_addr_o           (data_addr_o),
        .data_wdata_o          (data_wdata_o),
        .data_gnt_i            (data_gnt_i),
        .data_rvalid_i         (data_rvalid_i),
        .data_rdata_i          (data_rdata_i),
        .data_err_i            (data_err_i),
        .unexp_rvalid_o        (unexp_rvalid_o)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference model: list of outstanding owners (1 = engine) and the beat that
    // is on the bus awaiting grant, if any.
    bit          own_q[$];
    bit          pend_v = 0;
    bit          pend_own, pend_we;
    bit [3:0]    pend_be;
    bit [31:0]   pend_addr;
    bit [32:0]   pend_wdata;

    bit          e_req, e_own, e_we, e_cgnt, e_done, e_pop, e_head;
    bit [3:0]    e_be;
    bit [31:0]   e_addr;
    bit [32:0]   e_wdata;

    task automatic check_now();
        @(negedge clk_i);
        e_req = 0; e_own = 0; e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
        if (pend_v) begin
            e_req = 1; e_own = pend_own; e_we = pend_we; e_be = pend_be;
            e_addr = pend_addr; e_wdata = pend_wdata;
        end else if (own_q.size() < MAX && core_req_i) begin
            e_req = 1; e_own = 0; e_we = core_we_i; e_be = core_be_i;
            e_addr = core_addr_i & 32'hFFFF_FFFC; e_wdata = core_wdata_i;
        end else if (own_q.size() < MAX && stkz_lsu_req_i) begin
            e_req = 1; e_own = 1; e_we = 1; e_be = 4'hF;
            e_addr = stkz_lsu_addr_i & 32'hFFFF_FFFC; e_wdata = '0;
        end
        e_cgnt = e_req && data_gnt_i && !e_own;
        e_done = e_req && data_gnt_i && e_own;
        e_pop  = data_rvalid_i && (own_q.size() > 0);
        e_head = (own_q.size() > 0) ? own_q[0] : 1'b0;

        chk_val("data_req", 64'(data_req_o), 64'(e_req));
        if (e_req) begin
            chk_val("data_we", 64'(data_we_o), 64'(e_we));
            chk_val("data_be", 64'(data_be_o), 64'(e_be));
            chk_val("data_addr", 64'(data_addr_o), 64'(e_addr));
            chk_val("data_wdata", 64'(data_wdata_o), 64'(e_wdata));
        end
        chk_val("core_gnt", 64'(core_gnt_o), 64'(e_cgnt));
        chk_val("stkz_done", 64'(lsu_stkz_req_done_o), 64'(e_done));
        chk_val("core_rvalid", 64'(core_rvalid_o), 64'(e_pop && !e_head));
        chk_val("stkz_rvalid", 64'(lsu_stkz_resp_valid_o), 64'(e_pop && e_head));
        chk_val("unexp", 64'(unexp_rvalid_o), 64'(data_rvalid_i && own_q.size() == 0));
        if (e_pop && !e_head) begin
            chk_val("core_rdata", 64'(core_rdata_o), 64'(data_rdata_i));
            chk_val("core_err", 64'(core_err_o), 64'(data_err_i));
        end
        if (e_pop && e_head)
            chk_val("stkz_err", 64'(lsu_stkz_resp_err_o), 64'(data_err_i));
    endtask

    task automatic advance();
        @(posedge clk_i);
        if (e_pop) void'(own_q.pop_front());
        if (e_cgnt || e_done) begin
            own_q.push_back(e_own);
            pend_v = 0;
        end else if (e_req) begin
            pend_v = 1; pend_own = e_own; pend_we = e_we; pend_be = e_be;
            pend_addr = e_addr; pend_wdata = e_wdata;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        core_req_i = 0; stkz_lsu_req_i = 0; data_gnt_i = 0;
        data_rvalid_i = 0; data_err_i = 0;
        rst_ni = 0;
        own_q.delete();
        pend_v = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            chk_val("rst_data_req", 64'(data_req_o), 64'd0);
            chk_val("rst_data_addr", 64'(data_addr_o), 64'd0);
            chk_val("rst_data_wdata", 64'(data_wdata_o), 64'd0);
            chk_val("rst_core_gnt", 64'(core_gnt_o), 64'd0);
            chk_val("rst_core_rvalid", 64'(core_rvalid_o), 64'd0);
            chk_val("rst_stkz_done", 64'(lsu_stkz_req_done_o), 64'd0);
            chk_val("rst_stkz_rvalid", 64'(lsu_stkz_resp_valid_o), 64'd0);
            chk_val("rst_unexp", 64'(unexp_rvalid_o), 64'd0);
        end
        @(posedge clk_i);
        #1 rst_ni = 1;
    endtask

    task automatic drain();
        for (int g = 0; g < 8 && own_q.size() > 0; g++) begin
            data_rvalid_i = 1;
            data_rdata_i  = {1'($urandom), $urandom};
            data_err_i    = 0;
            check_now();
            advance();
        end
        data_rvalid_i = 0;
        chk_val("drain_empty", 64'(own_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);

        // Core load: grant same cycle, response two cycles later.
        core_req_i = 1; core_we_i = 0; core_be_i = 4'hF;
        core_addr_i = 32'h1000_0002; core_wdata_i = '0; data_gnt_i = 1;
        check_now();
        chk_val("t1_gnt", 64'(core_gnt_o), 64'd1);
        chk_val("t1_addr", 64'(data_addr_o), 64'h1000_0000);
        advance();
        core_req_i = 0; data_gnt_i = 0;
        check_now(); advance();
        data_rvalid_i = 1; data_rdata_i = 33'h1_DEADBEEF;
        check_now();
        chk_val("t1_rvalid", 64'(core_rvalid_o), 64'd1);
        chk_val("t1_rdata", 64'(core_rdata_o), 64'h1_DEADBEEF);
        chk_val("t1_stkz_quiet", 64'(lsu_stkz_resp_valid_o), 64'd0);
        advance();
        data_rvalid_i = 0;

        // Lone zeroization beat with unaligned address; errored response.
        stkz_lsu_req_i = 1; stkz_lsu_addr_i = 32'h8000_0107; data_gnt_i = 1;
        check_now();
        chk_val("t2_addr", 64'(data_addr_o), 64'h8000_0104);
        chk_val("t2_wdata", 64'(data_wdata_o), 64'd0);
        chk_val("t2_be", 64'(data_be_o), 64'hF);
        chk_val("t2_we", 64'(data_we_o), 64'd1);
        chk_val("t2_done", 64'(lsu_stkz_req_done_o), 64'd1);
        advance();
        stkz_lsu_req_i = 0; data_gnt_i = 0;
        check_now();
        chk_val("t2_done_pulse", 64'(lsu_stkz_req_done_o), 64'd0);
        advance();
        data_rvalid_i = 1; data_err_i = 1;
        check_now();
        chk_val("t2_resp_err", 64'(lsu_stkz_resp_err_o), 64'd1);
        chk_val("t2_core_quiet", 64'(core_rvalid_o), 64'd0);
        advance();
        data_rvalid_i = 0; data_err_i = 0;

        // Simultaneous requests: core first, engine the cycle after.
        core_req_i = 1; core_we_i = 1; core_be_i = 4'h3;
        core_addr_i = 32'h2000_0010; core_wdata_i = 33'h0_1234_5678;
        stkz_lsu_req_i = 1; stkz_lsu_addr_i = 32'h8000_0200; data_gnt_i = 1;
        check_now();
        chk_val("t3_core_first", 64'(core_gnt_o), 64'd1);
        chk_val("t3_stkz_wait", 64'(lsu_stkz_req_done_o), 64'd0);
        advance();
        core_req_i = 0;
        check_now();
        chk_val("t3_stkz_next", 64'(lsu_stkz_req_done_o), 64'd1);
        advance();
        stkz_lsu_req_i = 0; data_gnt_i = 0;
        drain();

        // Engine beat stalled; core arrives and engine drops, beat must stay put.
        stkz_lsu_req_i = 1; stkz_lsu_addr_i = 32'h0000_2008; data_gnt_i = 0;
        check_now();
        chk_val("t4_addr0", 64'(data_addr_o), 64'h2008);
        advance();
        core_req_i = 1; core_we_i = 1; core_be_i = 4'h3;
        core_addr_i = 32'h3000_0000; core_wdata_i = 33'h1_0000_00AA;
        check_now();
        chk_val("t4_no_core_gnt", 64'(core_gnt_o), 64'd0);
        chk_val("t4_addr1", 64'(data_addr_o), 64'h2008);
        advance();
        stkz_lsu_req_i = 0; stkz_lsu_addr_i = 32'h0000_5550;
        check_now();
        chk_val("t4_addr2", 64'(data_addr_o), 64'h2008);
        chk_val("t4_wdata2", 64'(data_wdata_o), 64'd0);
        advance();
        data_gnt_i = 1;
        check_now();
        chk_val("t4_done", 64'(lsu_stkz_req_done_o), 64'd1);
        chk_val("t4_core_still_wait", 64'(core_gnt_o), 64'd0);
        advance();
        check_now();
        chk_val("t4_core_follows", 64'(core_gnt_o), 64'd1);
        chk_val("t4_core_addr", 64'(data_addr_o), 64'h3000_0000);
        advance();
        core_req_i = 0; data_gnt_i = 0;
        drain();

        // Fill to capacity, then responses free slots.
        core_req_i = 1; core_we_i = 0; core_be_i = 4'hF;
        core_addr_i = 32'h0000_0100; core_wdata_i = '0; data_gnt_i = 1;
        check_now(); chk_val("t5_g1", 64'(core_gnt_o), 64'd1); advance();
        check_now(); chk_val("t5_g2", 64'(core_gnt_o), 64'd1); advance();
        check_now(); chk_val("t5_full_block", 64'(data_req_o), 64'd0); advance();
        data_rvalid_i = 1; data_rdata_i = 33'h0_0000_0001;
        check_now(); chk_val("t5_block_on_rsp", 64'(data_req_o), 64'd0); advance();
        data_rdata_i = 33'h0_0000_0002;
        check_now(); chk_val("t5_gnt_and_rsp", 64'(core_gnt_o), 64'd1); advance();
        data_rvalid_i = 0;
        check_now(); chk_val("t5_refill", 64'(core_gnt_o), 64'd1); advance();
        check_now(); chk_val("t5_refull_block", 64'(data_req_o), 64'd0); advance();
        core_req_i = 0; data_gnt_i = 0;
        drain();

        // Response with nothing outstanding.
        data_rvalid_i = 1; data_rdata_i = 33'h1_5555_AAAA;
        check_now();
        chk_val("t6_unexp", 64'(unexp_rvalid_o), 64'd1);
        chk_val("t6_no_core", 64'(core_rvalid_o), 64'd0);
        advance();
        data_rvalid_i = 0;
        check_now();
        chk_val("t6_unexp_pulse", 64'(unexp_rvalid_o), 64'd0);
        advance();

        // Reset with a beat outstanding; its late response is flagged.
        core_req_i = 1; core_we_i = 0; core_addr_i = 32'h4000_0000; data_gnt_i = 1;
        check_now(); advance();
        core_req_i = 0; data_gnt_i = 0;
        do_reset(2);
        data_rvalid_i = 1;
        check_now();
        chk_val("t7_late_unexp", 64'(unexp_rvalid_o), 64'd1);
        advance();
        data_rvalid_i = 0;

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (!core_req_i && $urandom % 3 == 0) begin
                core_req_i   = 1;
                core_we_i    = 1'($urandom);
                core_be_i    = 4'($urandom);
                core_addr_i  = $urandom;
                core_wdata_i = {1'($urandom), $urandom};
            end
            if (!stkz_lsu_req_i) begin
                if ($urandom % 4 == 0) begin
                    stkz_lsu_req_i  = 1;
                    stkz_lsu_addr_i = $urandom;
                end
            end else if (!(pend_v && pend_own)) begin
                if ($urandom % 10 == 0) stkz_lsu_req_i = 0;
                else if ($urandom % 10 == 0) stkz_lsu_addr_i = $urandom;
            end
            data_gnt_i    = 1'($urandom);
            data_rvalid_i = (own_q.size() > 0) ? ($urandom % 5 < 2) : ($urandom % 25 == 0);
            data_rdata_i  = {1'($urandom), $urandom};
            data_err_i    = ($urandom % 8 == 0);
            check_now();
            advance();
            if (e_cgnt) core_req_i = 0;
            if (e_done) stkz_lsu_req_i = 0;
        end
        core_req_i = 0; stkz_lsu_req_i = 0; data_gnt_i = 0;
        check_now(); advance();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
